pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order IF/ID/EX/MEM/WB pipeline.
- Successor to the hazard-free pipeline: tracks in-flight register writes across STAGES post-decode slots.
- Detects RAW hazards for the instruction in ID and issues forwarding selects, load-use stalls, or full interlock stalls (FWD_EN=0).
- Handles branch flush and provides a stall counter plus retire trace for debug.

Parameters:
REG_AW, 5, register-index width (32 GPRs).
STAGES, 3, post-decode slots tracked; slot0=EX, slot1=MEM, slot STAGES-1=WB; legal range 2..7.
FWD_EN, 1, 1 = forwarding enabled, stall only on load-use; 0 = stall on any RAW match.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a valid instruction
id_rs  in  REG_AW  source register rs
id_rt  in  REG_AW  source register rt
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rwd  in  REG_AW  destination register
id_wen  in  1  instruction writes id_rwd
id_is_load  in  1  result comes from MEM stage (lw)
flush  in  1  branch taken in EX: kill the ID instruction and slot0
stall_id  out  1  hold IF/ID; combinational
issue  out  1  ID instruction enters slot0 this cycle; combinational
fwd_rs_sel  out  3  0=regfile, k+1=forward from slot k
fwd_rt_sel  out  3  same encoding for rt
stage_valid  out  STAGES  per-slot valid, bit0=slot0
stage_rwd  out  STAGES*REG_AW  per-slot destination, slot0 in LSBs
retire  out  1  valid & wen of the last slot
retire_rwd  out  REG_AW  destination of the last slot
stall_cnt  out  CNT_W  cycles with id_valid & stall_id, saturating

Behaviour:
- Slot record: {valid, wen, is_load, rwd}. Each clk, slot[i] <= slot[i-1] for i>=1. slot0 <= ID record if issue, else a bubble (valid=0).
- Pipeline slots never freeze: stalls insert bubbles only.
- Reset (rst=1 at clk edge): all slot valid/wen/is_load=0, rwd=0, stall_cnt=0. Outputs: stage_valid=0, retire=0, retire_rwd=0, stall_cnt=0. fwd sel and stall_id follow the combinational rules over empty slots, so they are 0.
- Match on source s (rs or rt): requires use_s=1, s!=0, slot k valid & wen, rwd==s. Register 0 never hazards.
- When several slots match, the youngest (lowest k) wins.
- FWD_EN=1: stall if the youngest match is slot0 with is_load=1. Otherwise fwd_sel = youngest match k+1, or 0 with no match.
- FWD_EN=0: stall on any match; fwd_sel always 0.
- stall_id = id_valid & (hazard on rs | hazard on rt). fwd_sel is forced to 0 when id_valid=0.
- issue = id_valid & ~stall_id & ~flush.
- flush=1: slot0 becomes a bubble at the next edge, overriding the issue and clearing the current slot0 record; older slots advance normally.
- flush with a simultaneous stall: flush wins; stall_cnt still counts the cycle.
- stall_cnt increments when id_valid & stall_id. It holds at 2^CNT_W-1. rst mid-run clears it on the same edge.
- retire/retire_rwd reflect slot STAGES-1 combinationally. Latency from issue to retire = STAGES cycles.
- rst asserted mid-operation discards all in-flight records; first issue after release sees no hazards.

Test Plan:
- Issue add r3 (wen, rwd=3), then sub using rs=3, FWD_EN=1 -> cycle 2: fwd_rs_sel=1, stall_id=0; retire with retire_rwd=3 three cycles after issue.
- lw r5 followed by add rs=5 -> stall_id=1 for one cycle, stall_cnt 0->1, bubble in slot0; next cycle fwd_rs_sel=2, issue=1.
- FWD_EN=0, add r4 then or rt=4 -> stall_id=1 for 3 cycles (slot0..2 matches), stall_cnt=3, then fwd_rt_sel=0, issue=1.
- Writes to r7 in slot0 and slot1, ID reads rs=7 and rt=7 -> both sels=1 (youngest); and with rs=0 and a slot writing r0 -> fwd_rs_sel=0, no stall.
- flush=1 with valid slot0 and id_valid=1 -> next cycle stage_valid[0]=0, slot1 unchanged from the prior slot0? no: slot1 receives bubble; retire shows no record from the killed slot.
- Drive a hazard continuously with CNT_W=4 -> stall_cnt saturates at 15; assert rst -> all outputs 0 next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard / forwarding controller for an in-order pipeline: tracks in-flight
// register writes in STAGES post-decode slots and decides forward, stall or issue.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [REG_AW-1:0]        id_rwd,
  input  logic                     id_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall_id,
  output logic                     issue,
  output logic [2:0]               fwd_rs_sel,
  output logic [2:0]               fwd_rt_sel,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*REG_AW-1:0] stage_rwd,
  output logic                     retire,
  output logic [REG_AW-1:0]        retire_rwd,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             wen_q, wen_d;
  logic [STAGES-1:0][REG_AW-1:0] rwd_q, rwd_d;
  // The load flag only matters while the producer sits in slot0 (EX); from MEM on it forwards.
  logic                          load0_q, load0_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

  logic [3:0] rs_match, rt_match;
  logic [3:0] rs_res, rt_res;

  // Returns {hit, slot}; scanning oldest to youngest lets the youngest match overwrite.
  function automatic logic [3:0] youngest(
    input logic                          use_s,
    input logic [REG_AW-1:0]             src,
    input logic [STAGES-1:0]             v,
    input logic [STAGES-1:0]             w,
    input logic [STAGES-1:0][REG_AW-1:0] rd
  );
    logic [3:0] r;
    r = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (use_s && (src != '0) && v[k] && w[k] && (rd[k] == src))
        r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  // Returns {hazard, forward select} for one source operand.
  function automatic logic [3:0] resolve(input logic [3:0] m, input logic ld0);
    logic       haz;
    logic [2:0] sel;
    haz = 1'b0;
    sel = '0;
    if (FWD_EN != 0) begin
      haz = m[3] && (m[2:0] == 3'd0) && ld0;
      if (m[3] && !haz)
        sel = m[2:0] + 3'd1;
    end else begin
      haz = m[3];
    end
    return {haz, sel};
  endfunction

  always_comb begin
    rs_match   = youngest(id_use_rs, id_rs, valid_q, wen_q, rwd_q);
    rt_match   = youngest(id_use_rt, id_rt, valid_q, wen_q, rwd_q);
    rs_res     = resolve(rs_match, load0_q);
    rt_res     = resolve(rt_match, load0_q);
    stall_id   = id_valid & (rs_res[3] | rt_res[3]);
    issue      = id_valid & ~stall_id & ~flush;
    fwd_rs_sel = id_valid ? rs_res[2:0] : 3'd0;
    fwd_rt_sel = id_valid ? rt_res[2:0] : 3'd0;
  end

  // Slot advance: slot0 takes the issued record or a bubble; flush also kills the record leaving slot0.
  always_comb begin
    valid_d    = '0;
    wen_d      = '0;
    rwd_d      = '0;
    valid_d[0] = issue;
    wen_d[0]   = issue & id_wen;
    rwd_d[0]   = issue ? id_rwd : '0;
    load0_d    = issue & id_is_load;
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1] & ~((i == 1) && flush);
      wen_d[i]   = wen_q[i-1] & ~((i == 1) && flush);
      rwd_d[i]   = ((i == 1) && flush) ? '0 : rwd_q[i-1];
    end
    stall_cnt_d = (stall_id && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wen_q       <= '0;
      rwd_q       <= '0;
      load0_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wen_q       <= wen_d;
      rwd_q       <= rwd_d;
      load0_q     <= load0_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stage_valid = valid_q;
  assign stage_rwd   = rwd_q;
  assign retire      = valid_q[STAGES-1] & wen_q[STAGES-1];
  assign retire_rwd  = rwd_q[STAGES-1];
  assign stall_cnt   = stall_cnt_q;

endmodule
